snake_game_ctrl: RTL and testbench

SNAKE_GAME_CTRL -- requirements
Module: snake_game_ctrl

---
 rtl/snake_game_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_snake_game_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/snake_game_ctrl.sv
// -----------------------------------------------------------------------------
// snake_game_ctrl
//
// Game-flow controller for a snake game. It sequences the game through
// RESTART -> START -> PLAY -> DIE, generates the snake step pulse, blinks the
// snake after a collision and manages two timed rewards (protection against
// collisions, and a slower move rate).
//
// Ports
//   clk              single clock
//   rst              synchronous active-high reset
//   key_start        one-cycle start/restart key pulse
//   hit_wall         collision with the playfield border
//   hit_body         collision with the snake's own body
//   req_protected    one-cycle grant of the protection reward
//   req_slowly       one-cycle grant of the slow-motion reward
//   game_status      00 RESTART, 01 START, 10 PLAY, 11 DIE
//   move_tick        one-cycle pulse per snake step
//   die_flash        1 = draw the snake (blinks while dying)
//   reward_protected protection reward active
//   reward_slowly    slow-motion reward active
// -----------------------------------------------------------------------------
module snake_game_ctrl #(
    parameter int TICK_BASE    = 12_500_000,
    parameter int TICK_SLOW    = 25_000_000,
    parameter int FLASH_HALF   = 12_500_000,
    parameter int FLASH_COUNT  = 3,
    parameter int REWARD_MOVES = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_start,
    input  logic       hit_wall,
    input  logic       hit_body,
    input  logic       req_protected,
    input  logic       req_slowly,
    output logic [1:0] game_status,
    output logic       move_tick,
    output logic       die_flash,
    output logic       reward_protected,
    output logic       reward_slowly
);

    typedef enum logic [1:0] {
        ST_RESTART = 2'b00,
        ST_START   = 2'b01,
        ST_PLAY    = 2'b10,
        ST_DIE     = 2'b11
    } state_t;

    localparam logic [31:0] TICK_BASE_M1  = 32'(TICK_BASE - 1);
    localparam logic [31:0] TICK_SLOW_M1  = 32'(TICK_SLOW - 1);
    localparam logic [31:0] FLASH_HALF_M1 = 32'(FLASH_HALF - 1);
    // The entry drop to 0 counts as the first toggle, so blinking is over
    // after 2*FLASH_COUNT half-periods.
    localparam logic [31:0] FLASH_HALVES  = 32'(2 * FLASH_COUNT);
    localparam logic [7:0]  REWARD_LOAD   = 8'(REWARD_MOVES);

    state_t      state_q, state_d;
    logic [31:0] tick_cnt_q, tick_cnt_d;
    logic        move_tick_q, move_tick_d;
    logic        die_flash_q, die_flash_d;
    logic [31:0] flash_cnt_q, flash_cnt_d;
    logic [31:0] half_cnt_q, half_cnt_d;
    logic        prot_q, prot_d;
    logic        slow_q, slow_d;
    logic [7:0]  prot_cnt_q, prot_cnt_d;
    logic [7:0]  slow_cnt_q, slow_cnt_d;

    logic [31:0] tick_limit;
    logic        collision;
    logic        blink_done;

    // Period follows the registered slow flag; the >= compare means a switch
    // back to the short period with a large count ticks at once.
    assign tick_limit = slow_q ? TICK_SLOW_M1 : TICK_BASE_M1;
    assign collision  = hit_wall | hit_body;
    assign blink_done = (half_cnt_q >= FLASH_HALVES);

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = 32'd0;
        move_tick_d = 1'b0;
        die_flash_d = die_flash_q;
        flash_cnt_d = flash_cnt_q;
        half_cnt_d  = half_cnt_q;
        prot_d      = prot_q;
        slow_d      = slow_q;
        prot_cnt_d  = prot_cnt_q;
        slow_cnt_d  = slow_cnt_q;

        case (state_q)
            ST_RESTART: begin
                state_d     = ST_START;
                die_flash_d = 1'b1;
                flash_cnt_d = 32'd0;
                half_cnt_d  = 32'd0;
                prot_d      = 1'b0;
                slow_d      = 1'b0;
                prot_cnt_d  = 8'd0;
                slow_cnt_d  = 8'd0;
            end

            ST_START: begin
                die_flash_d = 1'b1;
                if (key_start) begin
                    state_d = ST_PLAY;
                end
            end

            ST_PLAY: begin
                if (collision && !prot_q) begin
                    // Dying wins over any reward request in the same cycle.
                    state_d     = ST_DIE;
                    die_flash_d = 1'b0;
                    flash_cnt_d = 32'd0;
                    half_cnt_d  = 32'd0;
                    prot_d      = 1'b0;
                    slow_d      = 1'b0;
                    prot_cnt_d  = 8'd0;
                    slow_cnt_d  = 8'd0;
                end else begin
                    if (tick_cnt_q >= tick_limit) begin
                        move_tick_d = 1'b1;
                        tick_cnt_d  = 32'd0;
                    end else begin
                        tick_cnt_d  = tick_cnt_q + 32'd1;
                    end

                    // Rewards count down on the visible step pulse; a new
                    // request reloads and beats a coincident decrement.
                    if (req_protected) begin
                        prot_d     = 1'b1;
                        prot_cnt_d = REWARD_LOAD;
                    end else if (move_tick_q && (prot_cnt_q != 8'd0)) begin
                        prot_cnt_d = prot_cnt_q - 8'd1;
                        if (prot_cnt_q == 8'd1) begin
                            prot_d = 1'b0;
                        end
                    end

                    if (req_slowly) begin
                        slow_d     = 1'b1;
                        slow_cnt_d = REWARD_LOAD;
                    end else if (move_tick_q && (slow_cnt_q != 8'd0)) begin
                        slow_cnt_d = slow_cnt_q - 8'd1;
                        if (slow_cnt_q == 8'd1) begin
                            slow_d = 1'b0;
                        end
                    end
                end
            end

            ST_DIE: begin
                if (blink_done) begin
                    die_flash_d = 1'b1;
                    if (key_start) begin
                        state_d = ST_RESTART;
                    end
                end else if (flash_cnt_q == FLASH_HALF_M1) begin
                    flash_cnt_d = 32'd0;
                    half_cnt_d  = half_cnt_q + 32'd1;
                    // Odd half-periods show the snake; once the last half
                    // ends the snake stays drawn.
                    die_flash_d = half_cnt_d[0] | (half_cnt_d >= FLASH_HALVES);
                end else begin
                    flash_cnt_d = flash_cnt_q + 32'd1;
                end
            end

            default: begin
                state_d = ST_RESTART;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RESTART;
            tick_cnt_q  <= 32'd0;
            move_tick_q <= 1'b0;
            die_flash_q <= 1'b1;
            flash_cnt_q <= 32'd0;
            half_cnt_q  <= 32'd0;
            prot_q      <= 1'b0;
            slow_q      <= 1'b0;
            prot_cnt_q  <= 8'd0;
            slow_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            move_tick_q <= move_tick_d;
            die_flash_q <= die_flash_d;
            flash_cnt_q <= flash_cnt_d;
            half_cnt_q  <= half_cnt_d;
            prot_q      <= prot_d;
            slow_q      <= slow_d;
            prot_cnt_q  <= prot_cnt_d;
            slow_cnt_q  <= slow_cnt_d;
        end
    end

    assign game_status      = state_q;
    assign move_tick        = move_tick_q;
    assign die_flash        = die_flash_q;
    assign reward_protected = prot_q;
    assign reward_slowly    = slow_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_snake_game_ctrl
//
// Directed bench for snake_game_ctrl with small timing parameters
// (TICK_BASE=4, TICK_SLOW=8, FLASH_HALF=2, FLASH_COUNT=2, REWARD_MOVES=3).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_snake_game_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_start = 1'b0;
    logic       hit_wall = 1'b0;
    logic       hit_body = 1'b0;
    logic       req_protected = 1'b0;
    logic       req_slowly = 1'b0;
    logic [1:0] game_status;
    logic       move_tick;
    logic       die_flash;
    logic       reward_protected;
    logic       reward_slowly;

    int total = 0;
    int bad   = 0;

    snake_game_ctrl #(
        .TICK_BASE    (4),
        .TICK_SLOW    (8),
        .FLASH_HALF   (2),
        .FLASH_COUNT  (2),
        .REWARD_MOVES (3)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .key_start        (key_start),
        .hit_wall         (hit_wall),
        .hit_body         (hit_body),
        .req_protected    (req_protected),
        .req_slowly       (req_slowly),
        .game_status      (game_status),
        .move_tick        (move_tick),
        .die_flash        (die_flash),
        .reward_protected (reward_protected),
        .reward_slowly    (reward_slowly)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Expected die_flash for the first ten DIE cycles.
    logic [9:0] flash_seq;
    logic       exp_tick;

    initial begin
        flash_seq = 10'b1111001100; // bit d = cycle d: 0,0,1,1,0,0,1,1,1,1

        // ---- reset state ----
        step();
        check("rst_status", 32'(game_status), 32'd0);
        check("rst_tick", 32'(move_tick), 32'd0);
        check("rst_flash", 32'(die_flash), 32'd1);
        check("rst_prot", 32'(reward_protected), 32'd0);
        check("rst_slow", 32'(reward_slowly), 32'd0);

        // ---- RESTART lasts one cycle, START holds; reward grants ignored ----
        rst = 1'b0;
        step();
        check("start_status", 32'(game_status), 32'd1);
        req_protected = 1'b1;
        req_slowly    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("start_hold", 32'(game_status), 32'd1);
            check("start_tick", 32'(move_tick), 32'd0);
        end
        check("start_noprot", 32'(reward_protected), 32'd0);
        check("start_noslow", 32'(reward_slowly), 32'd0);
        req_protected = 1'b0;
        req_slowly    = 1'b0;

        // ---- enter PLAY, base period 4 ----
        key_start = 1'b1;
        step();
        key_start = 1'b0;
        check("play_status", 32'(game_status), 32'd2);
        check("play_tick0", 32'(move_tick), 32'd0);
        for (int c = 1; c <= 12; c++) begin
            step();
            exp_tick = ((c % 4) == 0);
            check("base_tick", 32'(move_tick), 32'(exp_tick));
        end

        // ---- slow reward granted on a tick cycle (reload beats decrement) ----
        req_slowly = 1'b1;
        step();
        req_slowly = 1'b0;
        check("slow_on", 32'(reward_slowly), 32'd1);
        check("slow_t1", 32'(move_tick), 32'd0);
        for (int k = 2; k <= 28; k++) begin
            step();
            exp_tick = (k == 8) || (k == 16) || (k == 24) || (k == 28);
            check("slow_tick", 32'(move_tick), 32'(exp_tick));
            if (k == 24) check("slow_still_on", 32'(reward_slowly), 32'd1);
            if (k == 25) check("slow_off", 32'(reward_slowly), 32'd0);
        end

        // ---- protection reward: wall hits ignored for 3 ticks ----
        req_protected = 1'b1;
        step();
        req_protected = 1'b0;
        hit_wall      = 1'b1;
        check("prot_on", 32'(reward_protected), 32'd1);
        for (int k = 2; k <= 13; k++) begin
            step();
            check("prot_alive", 32'(game_status), 32'd2);
            exp_tick = ((k % 4) == 0);
            check("prot_tick", 32'(move_tick), 32'(exp_tick));
            if (k == 12) check("prot_still_on", 32'(reward_protected), 32'd1);
            if (k == 13) check("prot_off", 32'(reward_protected), 32'd0);
        end
        step();
        hit_wall = 1'b0;
        check("die_status", 32'(game_status), 32'd3);
        check("die_tick", 32'(move_tick), 32'd0);

        // ---- DIE blinking; early key presses ignored ----
        for (int d = 0; d <= 9; d++) begin
            check("die_flash", 32'(die_flash), 32'(flash_seq[d]));
            check("die_hold", 32'(game_status), 32'd3);
            key_start = (d == 3) || (d == 7) || (d == 9);
            step();
        end
        key_start = 1'b0;
        check("restart_status", 32'(game_status), 32'd0);
        check("restart_flash", 32'(die_flash), 32'd1);
        step();
        check("restart_to_start", 32'(game_status), 32'd1);

        // ---- collision with simultaneous protection grant ----
        key_start = 1'b1;
        step();
        key_start  = 1'b0;
        req_slowly = 1'b1;
        check("play2_status", 32'(game_status), 32'd2);
        step();
        req_slowly    = 1'b0;
        check("play2_slow", 32'(reward_slowly), 32'd1);
        hit_body      = 1'b1;
        req_protected = 1'b1;
        step();
        hit_body      = 1'b0;
        req_protected = 1'b0;
        check("coll_die", 32'(game_status), 32'd3);
        check("coll_noprot", 32'(reward_protected), 32'd0);
        check("coll_slow_clr", 32'(reward_slowly), 32'd0);
        check("coll_flash", 32'(die_flash), 32'd0);

        // ---- reset in DIE while snake hidden ----
        rst = 1'b1;
        step();
        check("rst_die_status", 32'(game_status), 32'd0);
        check("rst_die_flash", 32'(die_flash), 32'd1);
        check("rst_die_prot", 32'(reward_protected), 32'd0);
        check("rst_die_slow", 32'(reward_slowly), 32'd0);
        rst = 1'b0;
        step();
        check("rst_die_start", 32'(game_status), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
